// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed multiply/divide responder for the MIPS datapath.
//   A start pulse latches the operands. The unit then runs one iteration per
//   clock: a radix-2 Booth step for multiply, or a restoring step on operand
//   magnitudes for divide. After the last step it writes HI/LO and raises a
//   one-cycle done pulse. A divide by zero answers with a one-cycle DivZero
//   pulse and leaves HI/LO unchanged.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous active-low reset
//   MultCtrl  in   1      start signed multiply (sampled in IDLE only, has priority)
//   DivCtrl   in   1      start signed divide (sampled in IDLE only)
//   A, B      in   WIDTH  operands, captured on the start edge
//   HI, LO    out  WIDTH  mult: product high/low; div: remainder/quotient
//   Busy      out  1      high in MULT, DIV and DONE
//   MultDone  out  1      one-cycle pulse, multiply result on HI/LO
//   DivDone   out  1      one-cycle pulse, divide result on HI/LO
//   DivZero   out  1      one-cycle pulse, divisor was zero
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             MultDone,
  output logic             DivDone,
  output logic             DivZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE,
    S_DZERO
  } state_t;

  // Two's-complement negate when requested.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (-v) : v;
  endfunction

  // Magnitude of a signed operand. -2^(W-1) maps to 2^(W-1), which is still
  // representable as an unsigned W-bit value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return cond_neg(v, v[WIDTH-1]);
  endfunction

  // Control state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             mult_op_q, mult_op_d;
  logic             dz_q, dz_d;

  // Datapath state. For multiply {acc_q, qr_q, qm1_q} is the Booth register;
  // acc_q carries one guard bit so that subtracting a multiplicand of
  // -2^(W-1) cannot overflow. For divide acc_q holds the partial remainder
  // and qr_q shifts the dividend out while the quotient shifts in.
  logic signed [WIDTH:0]   acc_q;
  logic        [WIDTH-1:0] qr_q;
  logic                    qm1_q;
  logic        [WIDTH-1:0] m_q;
  logic                    negq_q, negr_q;

  // Booth step
  logic signed [WIDTH:0]   m_ext;
  logic signed [WIDTH:0]   acc_sum;
  logic signed [WIDTH:0]   booth_acc;
  logic        [WIDTH-1:0] booth_q;

  // Restoring divide step
  logic [WIDTH:0]   shift_rem;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_q;

  always_comb begin
    m_ext = $signed({m_q[WIDTH-1], m_q});
    case ({qr_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_ext;
      2'b10:   acc_sum = acc_q - m_ext;
      default: acc_sum = acc_q;
    endcase
    booth_acc = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    booth_q   = {acc_sum[0], qr_q[WIDTH-1:1]};

    shift_rem = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
    diff      = {1'b0, shift_rem} - {2'b00, m_q};
    div_rem   = diff[WIDTH+1] ? shift_rem : diff[WIDTH:0];
    div_q     = {qr_q[WIDTH-2:0], ~diff[WIDTH+1]};
  end

  // Next-state / output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mult_op_d = mult_op_q;
    dz_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MultCtrl) begin
          state_d   = S_MULT;
          cnt_d     = CNT_W'(WIDTH);
          mult_op_d = 1'b1;
        end else if (DivCtrl) begin
          mult_op_d = 1'b0;
          if (B != '0) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = S_DZERO;
          end
        end
      end
      // The counter reaches zero after the last iteration; the following
      // edge commits the result to HI/LO and enters DONE.
      S_MULT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = qr_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          hi_d    = cond_neg(acc_q[WIDTH-1:0], negr_q);
          lo_d    = cond_neg(qr_q, negq_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      // DivZero is registered, so the pulse appears the cycle after DZERO.
      S_DZERO: begin
        state_d = S_IDLE;
        dz_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mult_op_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mult_op_q <= mult_op_d;
      dz_q      <= dz_d;
    end
  end

  // Operand capture and iteration
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: begin
        if (MultCtrl) begin
          acc_q <= '0;
          qr_q  <= A;
          qm1_q <= 1'b0;
          m_q   <= B;
        end else if (DivCtrl) begin
          acc_q  <= '0;
          qr_q   <= mag(A);
          qm1_q  <= 1'b0;
          m_q    <= mag(B);
          negq_q <= A[WIDTH-1] ^ B[WIDTH-1];
          negr_q <= A[WIDTH-1];
        end
      end
      S_MULT: begin
        if (cnt_q != '0) begin
          acc_q <= booth_acc;
          qr_q  <= booth_q;
          qm1_q <= qr_q[0];
        end
      end
      S_DIV: begin
        if (cnt_q != '0) begin
          acc_q <= $signed(div_rem);
          qr_q  <= div_q;
        end
      end
      default: ;
    endcase
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Busy     = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_DONE);
  assign MultDone = (state_q == S_DONE) &&  mult_op_q;
  assign DivDone  = (state_q == S_DONE) && !mult_op_q;
  assign DivZero  = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MultCtrl, DivCtrl;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        Busy, MultDone, DivDone, DivZero;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference HI/LO as the architecture should hold them
  logic [31:0] hi_m, lo_m;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .MultCtrl (MultCtrl),
    .DivCtrl  (DivCtrl),
    .A        (A),
    .B        (B),
    .HI       (HI),
    .LO       (LO),
    .Busy     (Busy),
    .MultDone (MultDone),
    .DivDone  (DivDone),
    .DivZero  (DivZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain 64-bit signed arithmetic.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi_e, output logic [31:0] lo_e);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p    = sa * sb;
      hi_e = p[63:32];
      lo_e = p[31:0];
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      hi_e = r[31:0];
      lo_e = q[31:0];
    end
  endtask

  // Issue one operation and follow it cycle by cycle. rep > 0 re-pulses both
  // start lines so they are high on iteration edge rep.
  task automatic run_op(input string name, input bit is_mult,
                        input logic [31:0] a, input logic [31:0] b, input int rep);
    logic [31:0] hi_e, lo_e;
    int bad;
    @(negedge clk);
    A = a; B = b; MultCtrl = is_mult; DivCtrl = !is_mult;
    @(posedge clk); #1;                               // E0
    MultCtrl = 1'b0; DivCtrl = 1'b0;
    A = $urandom; B = $urandom;                       // late operand changes must not matter
    if (!is_mult && b == 32'd0) begin
      chk({name, ".dz_busy0"}, {31'd0, Busy}, 32'd0);
      @(posedge clk); #1;                             // E1
      chk({name, ".dz_pulse"}, {29'd0, DivZero, DivDone, Busy}, 32'd4);
      chk({name, ".dz_hi"}, HI, hi_m);
      chk({name, ".dz_lo"}, LO, lo_m);
      @(posedge clk); #1;                             // E2
      chk({name, ".dz_end"}, {30'd0, DivZero, DivDone}, 32'd0);
      return;
    end
    model(is_mult, a, b, hi_e, lo_e);
    chk({name, ".busy_e0"}, {31'd0, Busy}, 32'd1);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == rep) begin MultCtrl = 1'b1; DivCtrl = 1'b1; end
      @(posedge clk); #1;
      MultCtrl = 1'b0; DivCtrl = 1'b0;
      if (MultDone || DivDone || DivZero || !Busy || HI !== hi_m || LO !== lo_m) bad++;
    end
    chk({name, ".iter"}, bad, 32'd0);
    MultCtrl = 1'b1;                                  // start on the return-to-IDLE edge
    @(posedge clk); #1;                               // E33
    chk({name, ".done"}, {29'd0, MultDone, DivDone, Busy}, is_mult ? 32'd5 : 32'd3);
    chk({name, ".hi"}, HI, hi_e);
    chk({name, ".lo"}, LO, lo_e);
    hi_m = hi_e; lo_m = lo_e;
    @(posedge clk); #1;                               // E34
    MultCtrl = 1'b0;
    chk({name, ".e34"}, {29'd0, MultDone, DivDone, Busy}, 32'd0);
    @(posedge clk); #1;                               // E35
    chk({name, ".no_restart"}, {31'd0, Busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] corner [6];
    logic [31:0] ra, rb;
    bit          rm;
    corner = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h7FFF_FFFF, 32'd3};
    reset = 1'b0; MultCtrl = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outs", {HI ^ LO, 28'd0, Busy, MultDone, DivDone, DivZero}, 32'd0);
    chk("reset.hi", HI, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op("t1_mul", 1'b1, 32'd7, -32'sd3, 0);
    chk("t1_hi_const", HI, 32'hFFFF_FFFF);
    chk("t1_lo_const", LO, 32'hFFFF_FFEB);
    run_op("t2_mul", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    chk("t2_hi_const", HI, 32'h4000_0000);
    run_op("t3_div", 1'b0, -32'sd7, 32'd2, 0);
    chk("t3_lo_const", LO, 32'hFFFF_FFFD);
    chk("t3_hi_const", HI, 32'hFFFF_FFFF);
    run_op("t4_pre", 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("t4_dz", 1'b0, 32'd5, 32'd0, 0);
    run_op("t5_rep", 1'b1, 32'd1234567, -32'sd89, 10);
    run_op("wrap", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("wrap_lo_const", LO, 32'h8000_0000);

    // Reset in the middle of a divide
    @(negedge clk);
    A = 32'd1000; B = 32'd3; DivCtrl = 1'b1;
    @(posedge clk); #1; DivCtrl = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_outs", {28'd0, Busy, MultDone, DivDone, DivZero}, 32'd0);
    chk("t6_rst_hi", HI, 32'd0);
    chk("t6_rst_lo", LO, 32'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); reset = 1'b1;
    run_op("t6_div", 1'b0, 32'd100, 32'd7, 0);
    chk("t6_lo_const", LO, 32'd14);
    chk("t6_hi_const", HI, 32'd2);

    // Randomised operations with occasional corner operands
    for (int i = 0; i < 16; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 28);
      run_op($sformatf("rnd%0d", i), rm, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
